// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default buffer geometry
// shared by the transmit and receive RAMs.
package uart_pkg;

  localparam int UART_ADDR_W = 8;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/tx_ram_core.sv
// Single-clock dual-port byte RAM: synchronous write, registered read.
// rd_data follows rd_addr one cycle later; contents are never cleared by reset.
module tx_ram_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/transmit_ram.sv
// Transmit byte queue: host writes into a circular buffer, FSM drains it into the UART
// transmitter with a start/busy handshake. Optional TX_AUTO_SEND_EN drains without send.
module transmit_ram
  import uart_pkg::*;
#(
  parameter int ADDR_W      = UART_ADDR_W,
  parameter int DATA_W      = UART_DATA_W,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              send,
  input  logic              clr_overflow,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              sending,
  output logic              overflow
);

  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  tx_state_t         state, state_next;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] rd_data;
  logic [TW-1:0]     ack_cnt;
  logic              do_wr, do_pop;

  assign do_wr    = wr_en && !full;
  assign do_pop   = (state == ST_FETCH);
  assign tx_start = (state == ST_START);
  assign sending  = (state != ST_IDLE);

  tx_ram_core #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_core (
    .clk    (CLK100MHZ),
    .wr_en  (do_wr),
    .wr_addr(wptr),
    .wr_data(wr_data),
    .rd_addr(rptr),
    .rd_data(rd_data)
  );

  always_comb begin
    count_next = count;
    case ({do_wr, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Count spans 0..2**ADDR_W, so the MSB alone marks a full buffer.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)  wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= count_next[ADDR_W];
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tx_data <= '0;
      ack_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH)    tx_data <= rd_data;
      if (state == ST_START)    ack_cnt <= '0;
      if (state == ST_WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
`ifdef TX_AUTO_SEND_EN
        if (!empty) state_next = ST_FETCH;
`else
        if (send && !empty) state_next = ST_FETCH;
`endif
      end
      ST_FETCH: state_next = ST_START;
      ST_START: state_next = ST_WAIT_ACK;
      // No handshake within the window: re-issue the already popped byte.
      ST_WAIT_ACK: begin
        if (tx_busy)                         state_next = ST_WAIT_DONE;
        else if (ack_cnt == TW'(ACK_TIMEOUT)) state_next = ST_START;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_next = empty ? ST_IDLE : ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_transmit_ram.sv
// Directed bench for transmit_ram with a negedge transmitter model (busy 2 cycles after
// tx_start, held 10 cycles, optionally stuck high or never raised).
module tb_transmit_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       send = 1'b0;
  logic       clr_ov = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [8:0] count;
  logic       full, empty, sending, overflow;

  transmit_ram dut (
    .CLK100MHZ   (clk),
    .reset       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .send        (send),
    .clr_overflow(clr_ov),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .sending     (sending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       model_busy_en = 1'b1;
  logic       hold = 1'b0;
  int         dly = 0, bcnt = 0, cyc = 0, nstart = 0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int         st_cyc[$];

  initial tx_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tx_busy = 1'b0;
      dly = 0;
      bcnt = 0;
    end else if (tx_start) begin
      q.push_back(tx_data);
      st_cyc.push_back(cyc);
      nstart++;
      if (model_busy_en) dly = 2;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        tx_busy = 1'b1;
        bcnt = 10;
      end
    end else if (tx_busy && !hold) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic pulse_send;
    send = 1'b1;
    tick;
    send = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (sending === 1'b1 && n < bound) begin
      tick;
      n++;
    end
    check(tag, 32'(sending), 32'd0);
  endtask

  task automatic wait_starts(input string tag, input int target, input int bound);
    int n = 0;
    while (nstart < target && n < bound) begin
      tick;
      n++;
    end
    check(tag, 32'(nstart), 32'(target));
  endtask

  function automatic int seq_err(input int base);
    int e = (q.size() - base == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < q.size() && q[base + i] !== exp_q[i]) e++;
    return e;
  endfunction

  initial begin
    int qb, nb, sb, n;
    repeat (3) tick;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_sending", 32'(sending), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    tick;

`ifdef TX_AUTO_SEND_EN
    wr(8'h55);
    check("auto_count", 32'(count), 32'd1);
    check("auto_idle", 32'(sending), 32'd0);
    tick;
    check("auto_fetch", 32'(sending), 32'd1);
    check("auto_fetch_nostart", 32'(tx_start), 32'd0);
    tick;
    check("auto_start", 32'(tx_start), 32'd1);
    check("auto_data", 32'(tx_data), 32'h55);
    wait_idle("auto_drain", 200);
`else
    // Basic three-byte drain.
    qb = q.size();
    nb = nstart;
    wr(8'h41); wr(8'h42); wr(8'h43);
    check("t1_count3", 32'(count), 32'd3);
    check("t1_not_empty", 32'(empty), 32'd0);
    pulse_send;
    check("t1_fetch_sending", 32'(sending), 32'd1);
    check("t1_fetch_nostart", 32'(tx_start), 32'd0);
    tick;
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data0", 32'(tx_data), 32'h41);
    check("t1_count2", 32'(count), 32'd2);
    wait_idle("t1_drain", 200);
    exp_q.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    check("t1_seq", 32'(seq_err(qb)), 32'd0);
    check("t1_nstart", 32'(nstart - nb), 32'd3);
    check("t1_count0", 32'(count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    pulse_send;
    check("t1_send_empty_ignored", 32'(sending), 32'd0);

    // Fill to full, overflow, clear.
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      wr(8'(i));
      exp_q.push_back(8'(i));
    end
    check("t2_full", 32'(full), 32'd1);
    check("t2_count256", 32'(count), 32'd256);
    check("t2_no_ovf_yet", 32'(overflow), 32'd0);
    wr(8'hAA);
    check("t2_ovf_set", 32'(overflow), 32'd1);
    check("t2_count_hold", 32'(count), 32'd256);
    wr_en = 1'b1; wr_data = 8'hAA; clr_ov = 1'b1;
    tick;
    wr_en = 1'b0; clr_ov = 1'b0;
    check("t2_set_wins", 32'(overflow), 32'd1);
    clr_ov = 1'b1;
    tick;
    clr_ov = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);
    qb = q.size();
    pulse_send;
    wait_idle("t2_drain", 8000);
    check("t2_seq", 32'(seq_err(qb)), 32'd0);
    check("t2_count0", 32'(count), 32'd0);

    // Wrap-around: 255 in, 200 out (busy then held), 100 more in.
    exp_q.delete();
    for (int i = 0; i < 255; i++) begin
      wr(8'(i * 7 + 3));
      exp_q.push_back(8'(i * 7 + 3));
    end
    qb = q.size();
    nb = nstart;
    pulse_send;
    wait_starts("t3_200_started", nb + 200, 5000);
    hold = 1'b1;
    repeat (20) tick;
    check("t3_count55", 32'(count), 32'd55);
    for (int i = 0; i < 100; i++) begin
      wr(8'(8'hC0 ^ i));
      exp_q.push_back(8'(8'hC0 ^ i));
    end
    check("t3_count155", 32'(count), 32'd155);
    check("t3_not_full", 32'(full), 32'd0);
    hold = 1'b0;
    wait_idle("t3_drain", 8000);
    check("t3_seq", 32'(seq_err(qb)), 32'd0);

    // Transmitter never acknowledges: same byte re-issued every 1025 cycles.
    model_busy_en = 1'b0;
    wr(8'h77); wr(8'h78);
    qb = q.size();
    nb = nstart;
    sb = st_cyc.size();
    pulse_send;
    wait_starts("t4_three_starts", nb + 3, 4000);
    check("t4_period1", 32'((st_cyc.size() > sb + 1) ? st_cyc[sb + 1] - st_cyc[sb] : -1), 32'd1025);
    check("t4_period2", 32'((st_cyc.size() > sb + 2) ? st_cyc[sb + 2] - st_cyc[sb + 1] : -1), 32'd1025);
    check("t4_retry_data", 32'((q.size() > qb + 2) ? q[qb + 2] : 8'h00), 32'h77);
    check("t4_count1", 32'(count), 32'd1);
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    model_busy_en = 1'b1;
    tick;

    // Reset in the middle of the third frame request.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    qb = q.size();
    nb = nstart;
    pulse_send;
    n = 0;
    while (!(tx_start === 1'b1 && nstart - nb == 2) && n < 500) begin
      tick;
      n++;
    end
    check("t5_third_start_seen", 32'(n < 500), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_tx_start_drop", 32'(tx_start), 32'd0);
    check("t5_count0", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_sending", 32'(sending), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    nb = nstart;
    repeat (50) tick;
    check("t5_no_more_start", 32'(nstart - nb), 32'd0);
    check("t5_sent1", 32'((q.size() > qb + 1) ? q[qb + 1] : 8'h00), 32'h02);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
